// File: rtl/bird_pkg.sv
// Shared types and helpers for the bird vertical-motion controller.
package bird_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    DEAD = 2'd3
  } bird_state_t;

  // Row register width for a matrix of 'rows' rows (at least one bit).
  function automatic int row_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/upcounter_rise.sv
// Rise-tick sub-counter: counts while en, ticks at PERIOD and wraps to 0 on that cycle.
module upcounter_rise #(
  parameter int WIDTH  = 12,
  parameter int PERIOD = 1500
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD);

  logic [WIDTH-1:0] count;

  assign tick = (count == LAST);

  // Count register; clear wins over counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + WIDTH'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/bird_vertical.sv
// Bird vertical-motion controller: flap climbs via the rise counter, fall_tick drops.
// Optional feature macro: CEILING_KILL_EN (rise tick at row 0 kills the bird).
module bird_vertical
  import bird_pkg::*;
#(
  parameter int ROWS        = 16,
  parameter int START_ROW   = 8,
  parameter int RISE_PERIOD = 1500,
  parameter int RISE_STEPS  = 3,
  parameter int CNT_WIDTH   = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fall_tick,
  input  logic                        flap,
  input  logic                        enable,
  output logic [row_width(ROWS)-1:0]  row,
  output logic                        rising,
  output logic                        dead
);

  localparam int RW     = row_width(ROWS);
  localparam int STEP_W = $clog2(RISE_STEPS + 1);

  localparam logic [RW-1:0]     ROW_START = RW'(START_ROW);
  localparam logic [RW-1:0]     ROW_MAX   = RW'(ROWS - 1);
  localparam logic [RW-1:0]     ROW_TOP   = RW'(0);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RISE_STEPS);

  bird_state_t       state, state_next;
  logic [RW-1:0]     row_next;
  logic [STEP_W-1:0] steps, steps_next, steps_inc;
  logic              flap_q;
  logic              press;
  logic              rise_tick;
  logic              clear_cnt;

  // flap_q resets high so a key held through reset is not a press.
  assign press     = flap & ~flap_q;
  assign steps_inc = steps + STEP_W'(1);

  upcounter_rise #(
    .WIDTH  (CNT_WIDTH),
    .PERIOD (RISE_PERIOD)
  ) u_rise_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear_cnt),
    .en    (enable && (state == RISE)),
    .tick  (rise_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, row and step count; everything holds while enable is low.
  always_comb begin
    state_next = state;
    row_next   = row;
    steps_next = steps;
    clear_cnt  = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          row_next = ROW_START;
          if (press) begin
            state_next = RISE;
            steps_next = '0;
            clear_cnt  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
        RISE: begin
          if (press) begin
            steps_next = '0;
            clear_cnt  = 1'b1;
          end else if (rise_tick) begin
`ifdef CEILING_KILL_EN
            if (row == ROW_TOP) begin
              state_next = DEAD;
            end else begin
              row_next   = row - RW'(1);
              steps_next = steps_inc;
              if (steps_inc == STEP_LAST) begin
                state_next = FALL;
              end else begin
                state_next = RISE;
              end
            end
`else
            // Saturate at the top row; the step still counts.
            if (row == ROW_TOP) begin
              row_next = row;
            end else begin
              row_next = row - RW'(1);
            end
            steps_next = steps_inc;
            if (steps_inc == STEP_LAST) begin
              state_next = FALL;
            end else begin
              state_next = RISE;
            end
`endif
          end else begin
            state_next = RISE;
          end
        end
        FALL: begin
          if (press) begin
            state_next = RISE;
            steps_next = '0;
            clear_cnt  = 1'b1;
          end else if (fall_tick) begin
            if (row == ROW_MAX) begin
              state_next = DEAD;
            end else begin
              row_next = row + RW'(1);
            end
          end else begin
            state_next = FALL;
          end
        end
        DEAD: begin
          state_next = DEAD;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end else begin
      state_next = state;
    end
  end

  // Datapath and registered outputs, derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      row    <= ROW_START;
      steps  <= '0;
      flap_q <= 1'b1;
      rising <= 1'b0;
      dead   <= 1'b0;
    end else begin
      row    <= row_next;
      steps  <= steps_next;
      flap_q <= flap;
      rising <= (state_next == RISE);
      dead   <= (state_next == DEAD);
    end
  end

endmodule

// File: doc/bird_vertical.md
# bird_vertical

Vertical-motion controller for the Flappy Bird player sprite on the 16-row LED matrix. It is the rising counterpart to the fall-tick generator: it consumes the periodic fall tick to move the bird down and uses its own rise-tick sub-counter to move the bird up after a flap press. It outputs the bird row to the renderer and collision logic, and flags death on hitting the floor.

## Interface
- ROWS, 16, matrix rows; row 0 = top, ROWS-1 = floor
- START_ROW, 8, row loaded at reset
- RISE_PERIOD, 1500, rise tick asserted when rise count == RISE_PERIOD (period RISE_PERIOD+1 cycles)
- RISE_STEPS, 3, rows climbed per flap
- CNT_WIDTH, 12, rise counter width; must hold RISE_PERIOD
- clk  input  1  system clock
- reset  input  1  reset, synchronous, active-high; clock clk
- fall_tick  input  1  one-cycle pulse from the fall counter
- flap  input  1  synchronized flap key, active-high level
- enable  input  1  game running; low freezes motion
- row  output  $clog2(ROWS)  current bird row, registered
- rising  output  1  high while in RISE
- dead  output  1  high in DEAD

## Operation
- Flap press = flap & ~flap_q. flap_q is registered every cycle regardless of enable. It resets to 1, so a key held through reset must be released before it counts.
- States: IDLE, RISE, FALL, DEAD.
- IDLE: row = START_ROW. A press with enable → RISE. fall_tick is ignored.
- RISE, on entry or re-entry:
  - Clear the rise counter and steps.
  - On each rise tick: if row > 0, decrement row; increment steps. When steps reaches RISE_STEPS → FALL.
  - A press in RISE restarts the climb: counter and steps cleared, no row change that cycle.
  - fall_tick is ignored.
- FALL:
  - fall_tick with row < ROWS-1 → row+1.
  - fall_tick with row == ROWS-1 → DEAD, row held.
  - Press → RISE.
- DEAD: row held, dead=1. Presses and ticks are ignored; only reset exits.
- enable low:
  - State, row, steps and rise counter are frozen.
  - Presses and ticks are dropped, not queued.
- Simultaneous events:
  - Press + fall_tick in FALL → RISE, row unchanged.
  - Press + rise tick in RISE → restart, row unchanged.
- Reset mid-operation returns everything to reset values on the next edge.

## Timing
- Reset values: row=START_ROW, rising=0, dead=0, state=IDLE, steps=0, rise count=0, flap_q=1.
- Press sampled at edge k → rising=1 after edge k.
- First rise tick occurs RISE_PERIOD cycles after entry, giving the first row change RISE_PERIOD+1 cycles after edge k. Subsequent changes follow every RISE_PERIOD+1 cycles.
- fall_tick sampled at edge k → row update (or dead=1) visible after edge k.
- The rise counter wraps to 0 on the cycle its tick asserts and runs only in RISE with enable high.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- CEILING_KILL_EN defined: a rise tick while row == 0 → DEAD (dead=1, row stays 0).
- CEILING_KILL_EN undefined: row saturates at 0, and the step still counts toward RISE_STEPS.

## Structure
- Package bird_pkg:
  - typedef enum bird_state_t {IDLE, RISE, FALL, DEAD}
  - function/localparam for row width from ROWS
- Sub-module upcounter_rise #(WIDTH, PERIOD):
  - Ports: clk, reset, clear, en, tick.
  - Counts while en; clear zeroes the count.
  - tick = (count == PERIOD), and the count wraps to 0 on the same cycle.
- Remaining logic lives in bird_vertical: edge detect, FSM, row and steps registers.

## Test plan
Bench parameters: ROWS=16, START_ROW=8, RISE_PERIOD=4, RISE_STEPS=3, enable=1 unless stated.
- Reset with flap held high, release after reset, press → no motion before the release; after the press, rising=1.
- Single press from IDLE → row 8→7→6→5 at 5-cycle intervals, first change 5 cycles after the press edge, then rising=0.
- From FALL at row 5, 10 fall_tick pulses → row 15. 11th pulse → dead=1, row stays 15. Later press → no change.
- Press, second press when row reaches 6 → climb restarts, row ends at 3, then FALL.
- From row 1, press → row 0, then holds 0 and enters FALL after 3 steps with macro undefined; dead=1 on the second rise tick with CEILING_KILL_EN defined.
- Press coincident with fall_tick at row 10 → row stays 10, rising=1. With enable=0, press and fall_tick → no state or row change.
